// File: rtl/shift_reg_pkg.sv
// Shared types for the universal shift register: operation modes and burst FSM states.
package shift_reg_pkg;

  typedef enum logic [2:0] {
    SR_HOLD  = 3'd0,
    SR_SHL   = 3'd1,
    SR_SHR   = 3'd2,
    SR_ROL   = 3'd3,
    SR_ROR   = 3'd4,
    SR_ASR   = 3'd5,
    SR_LOAD  = 3'd6,
    SR_CLEAR = 3'd7
  } sr_mode_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } sr_state_t;

  // Only shift/rotate modes are allowed to drive a counted burst.
  function automatic logic is_shift_mode(input sr_mode_t m);
    return (m != SR_HOLD) && (m != SR_LOAD) && (m != SR_CLEAR);
  endfunction

endpackage

// File: rtl/shift_reg_univ_if.sv
// Control/data bundle for shift_reg_univ; PATTERN_MATCH_EN adds pattern/match.
interface shift_reg_univ_if #(
  parameter int WIDTH = 16,
  parameter int STEP  = 1,
  parameter int CNT_W = 8
);
  logic             en;
  logic [2:0]       mode;
  logic [STEP-1:0]  d_ser;
  logic [WIDTH-1:0] d_par;
  logic             start;
  logic [CNT_W-1:0] burst_len;
  logic [WIDTH-1:0] out;
  logic [STEP-1:0]  ser_out;
  logic             busy;
  logic             done;
`ifdef PATTERN_MATCH_EN
  logic [WIDTH-1:0] pattern;
  logic             match;
`endif

  modport master (
`ifdef PATTERN_MATCH_EN
    output pattern,
    input  match,
`endif
    output en, mode, d_ser, d_par, start, burst_len,
    input  out, ser_out, busy, done
  );

  modport slave (
`ifdef PATTERN_MATCH_EN
    input  pattern,
    output match,
`endif
    input  en, mode, d_ser, d_par, start, burst_len,
    output out, ser_out, busy, done
  );

endinterface

// File: rtl/shift_step_unit.sv
// Combinational single-step shifter/rotator; shared by the idle (en) and burst paths.
module shift_step_unit
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0] cur,
  input  sr_mode_t         mode,
  input  logic [STEP-1:0]  d_ser,
  output logic [WIDTH-1:0] nxt,
  output logic [STEP-1:0]  bits_out,
  output logic             shifted
);

  logic [STEP-1:0] sign_fill;

  generate
    for (genvar gi = 0; gi < STEP; gi++) begin : g_sign
      assign sign_fill[gi] = cur[WIDTH-1];
    end
  endgenerate

  always_comb begin
    nxt      = cur;
    bits_out = '0;
    shifted  = 1'b0;
    case (mode)
      SR_SHL: begin
        nxt      = {cur[WIDTH-STEP-1:0], d_ser};
        bits_out = cur[WIDTH-1 -: STEP];
        shifted  = 1'b1;
      end
      SR_SHR: begin
        nxt      = {d_ser, cur[WIDTH-1:STEP]};
        bits_out = cur[STEP-1:0];
        shifted  = 1'b1;
      end
      SR_ROL: begin
        nxt      = {cur[WIDTH-STEP-1:0], cur[WIDTH-1 -: STEP]};
        bits_out = cur[WIDTH-1 -: STEP];
        shifted  = 1'b1;
      end
      SR_ROR: begin
        nxt      = {cur[STEP-1:0], cur[WIDTH-1:STEP]};
        bits_out = cur[STEP-1:0];
        shifted  = 1'b1;
      end
      SR_ASR: begin
        nxt      = {sign_fill, cur[WIDTH-1:STEP]};
        bits_out = cur[STEP-1:0];
        shifted  = 1'b1;
      end
      default: begin
        nxt      = cur;
        bits_out = '0;
        shifted  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register with counted burst engine.
// Optional macro PATTERN_MATCH_EN: registered pattern match that also ends a burst early.
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 1,
  parameter int CNT_W = 8
) (
  input logic             clk,
  input logic             rst,
  shift_reg_univ_if.slave bus
);

  sr_state_t        state_reg;
  sr_mode_t         burst_mode_reg;
  logic [CNT_W-1:0] count_reg;
  logic [WIDTH-1:0] out_reg;
  logic [STEP-1:0]  ser_reg;
  logic             busy_reg;
  logic             done_reg;

  sr_mode_t         in_mode;
  sr_mode_t         step_mode;
  logic [WIDTH-1:0] step_next;
  logic [STEP-1:0]  step_bits;
  logic             step_shifted;
  logic [WIDTH-1:0] out_next;
  logic [STEP-1:0]  ser_next;
  logic             start_ok;
  logic             early_stop;

  assign in_mode  = sr_mode_t'(bus.mode);
  assign start_ok = bus.start && is_shift_mode(in_mode);

  always_comb begin
    step_mode = (state_reg == ST_BURST) ? burst_mode_reg : in_mode;
  end

  shift_step_unit #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .cur      (out_reg),
    .mode     (step_mode),
    .d_ser    (bus.d_ser),
    .nxt      (step_next),
    .bits_out (step_bits),
    .shifted  (step_shifted)
  );

  // The register value the next edge will produce; also feeds the pattern comparator.
  always_comb begin
    out_next = out_reg;
    ser_next = ser_reg;
    if (state_reg == ST_BURST) begin
      out_next = step_next;
      ser_next = step_bits;
    end else if (!start_ok && bus.en) begin
      case (in_mode)
        SR_LOAD:  out_next = bus.d_par;
        SR_CLEAR: out_next = '0;
        default:  out_next = step_next;
      endcase
      if (step_shifted) begin
        ser_next = step_bits;
      end
    end
  end

`ifdef PATTERN_MATCH_EN
  logic match_reg;
  logic match_next;

  assign match_next = (out_next == bus.pattern);
  assign early_stop = (state_reg == ST_BURST) && match_next && !match_reg;
  assign bus.match  = match_reg;
`else
  assign early_stop = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      burst_mode_reg <= SR_HOLD;
      count_reg      <= '0;
      out_reg        <= '0;
      ser_reg        <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
`ifdef PATTERN_MATCH_EN
      match_reg      <= 1'b0;
`endif
    end else begin
      out_reg  <= out_next;
      ser_reg  <= ser_next;
      done_reg <= 1'b0;
`ifdef PATTERN_MATCH_EN
      match_reg <= match_next;
`endif
      case (state_reg)
        ST_IDLE: begin
          if (start_ok) begin
            if (bus.burst_len == '0) begin
              done_reg <= 1'b1;
            end else begin
              burst_mode_reg <= in_mode;
              count_reg      <= bus.burst_len;
              state_reg      <= ST_BURST;
              busy_reg       <= 1'b1;
            end
          end
        end
        ST_BURST: begin
          if ((count_reg == CNT_W'(1)) || early_stop) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            count_reg <= '0;
          end else begin
            count_reg <= count_reg - CNT_W'(1);
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out     = out_reg;
  assign bus.ser_out = ser_reg;
  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Self-checking bench: two instances (STEP=1 and STEP=4) driven in lockstep against an arithmetic model.
module tb_shift_reg_univ;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        en, start, d_ser1;
  logic [2:0]  mode;
  logic [3:0]  d_ser4;
  logic [15:0] d_par, pat;
  logic [7:0]  burst_len;

  shift_reg_univ_if #(.WIDTH(16), .STEP(1), .CNT_W(8)) b1 ();
  shift_reg_univ_if #(.WIDTH(16), .STEP(4), .CNT_W(8)) b4 ();

  shift_reg_univ #(.WIDTH(16), .STEP(1), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  shift_reg_univ #(.WIDTH(16), .STEP(4), .CNT_W(8)) dut4 (.clk(clk), .rst(rst), .bus(b4));

  assign b1.en = en;       assign b4.en = en;
  assign b1.mode = mode;   assign b4.mode = mode;
  assign b1.start = start; assign b4.start = start;
  assign b1.d_par = d_par; assign b4.d_par = d_par;
  assign b1.burst_len = burst_len; assign b4.burst_len = burst_len;
  assign b1.d_ser = d_ser1;
  assign b4.d_ser = d_ser4;
`ifdef PATTERN_MATCH_EN
  assign b1.pattern = pat; assign b4.pattern = pat;
`endif

  logic [15:0] o_out [2];
  logic [3:0]  o_ser [2];
  logic        o_busy[2];
  logic        o_done[2];
  assign o_out[0] = b1.out;               assign o_out[1] = b4.out;
  assign o_ser[0] = {3'b000, b1.ser_out}; assign o_ser[1] = b4.ser_out;
  assign o_busy[0] = b1.busy;             assign o_busy[1] = b4.busy;
  assign o_done[0] = b1.done;             assign o_done[1] = b4.done;

  // Reference model state, one slot per instance
  logic [15:0] mout[2];
  logic [3:0]  mser[2];
  bit          mbusy[2], mdone[2];
  int          mcnt[2], dcnt[2];
  int          stp[2];
  int          tests = 0, fails = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mdl_shift(input logic [15:0] v, input int m, input logic [3:0] d, input int s);
    logic [31:0] x, dm, res;
    x  = {16'h0, v};
    dm = {28'h0, d} & ((32'd1 << s) - 32'd1);
    case (m)
      1: res = (x << s) | dm;
      2: res = (x >> s) | (dm << (16 - s));
      3: res = (x << s) | (x >> (16 - s));
      4: res = (x >> s) | (x << (16 - s));
      5: res = 32'($signed({{16{v[15]}}, v}) >>> s);
      default: res = x;
    endcase
    return res[15:0];
  endfunction

  function automatic logic [3:0] ser_bits(input logic [15:0] v, input int m, input int s);
    logic [31:0] x, r;
    x = {16'h0, v};
    if (m == 1 || m == 3) r = x >> (16 - s);
    else                  r = x & ((32'd1 << s) - 32'd1);
    return r[3:0];
  endfunction

  function automatic bit early(input int k, input logic [15:0] n);
`ifdef PATTERN_MATCH_EN
    return (n == pat) && (mout[k] != pat);
`else
    return (k < 0) && (n != n);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s%0d_out", tag, k),  32'(o_out[k]),  32'(mout[k]));
      chk($sformatf("%s%0d_ser", tag, k),  32'(o_ser[k]),  32'(mser[k]));
      chk($sformatf("%s%0d_busy", tag, k), 32'(o_busy[k]), 32'(mbusy[k]));
      chk($sformatf("%s%0d_done", tag, k), 32'(o_done[k]), 32'(mdone[k]));
    end
  endtask

  task automatic en_op(input int m, input logic [15:0] dp, input logic ds1, input logic [3:0] ds4,
                       input bit e, input string tag);
    logic [3:0] d;
    mode = 3'(m); d_par = dp; d_ser1 = ds1; d_ser4 = ds4; en = e; start = 1'b0;
    tick();
    en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mdone[k] = 1'b0;
      d = (k == 0) ? {3'b000, ds1} : ds4;
      if (e) begin
        if (m == 6) mout[k] = dp;
        else if (m == 7) mout[k] = 16'h0;
        else if (m >= 1 && m <= 5) begin
          mser[k] = ser_bits(mout[k], m, stp[k]);
          mout[k] = mdl_shift(mout[k], m, d, stp[k]);
        end
      end
    end
    $display("[TB] en_op %s mode=%0d en=%0d out=%h/%h", tag, m, e, o_out[0], o_out[1]);
    check_all(tag);
  endtask

  // dm: 0 random serial data, 1 alternating 1,0,1.. on the STEP=1 instance, 2 all ones
  task automatic run_burst(input int m, input int len, input int dm);
    int cyc;
    logic [3:0] d;
    logic [15:0] n;
    bit stop;
    mode = 3'(m); burst_len = 8'(len); start = 1'b1; en = 1'b0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mdone[k] = (len == 0);
      mbusy[k] = (len != 0);
      mcnt[k]  = len;
      dcnt[k]  = int'(o_done[k]);
    end
    check_all("bst_start");
    cyc = 0;
    while ((mbusy[0] || mbusy[1]) && cyc < 300) begin
      d_ser1 = (dm == 1) ? ((cyc % 2) == 0) : (dm == 2) ? 1'b1 : 1'($urandom);
      d_ser4 = (dm == 2) ? 4'hF : 4'($urandom);
      for (int k = 0; k < 2; k++) begin
        mdone[k] = 1'b0;
        if (mbusy[k]) begin
          d = (k == 0) ? {3'b000, d_ser1} : d_ser4;
          n = mdl_shift(mout[k], m, d, stp[k]);
          mser[k] = ser_bits(mout[k], m, stp[k]);
          stop = (mcnt[k] == 1) || early(k, n);
          mout[k] = n;
          if (stop) begin
            mbusy[k] = 1'b0;
            mdone[k] = 1'b1;
          end else begin
            mcnt[k]--;
          end
        end
      end
      tick();
      check_all("bst");
      for (int k = 0; k < 2; k++) dcnt[k] += int'(o_done[k]);
      cyc++;
    end
    chk("bst_bound", 32'(cyc < 300), 32'd1);
    $display("[TB] burst mode=%0d len=%0d cycles=%0d out=%h/%h", m, len, cyc, o_out[0], o_out[1]);
  endtask

  initial begin
    int r;
    stp[0] = 1; stp[1] = 4;
    en = 1'b0; mode = 3'd0; start = 1'b0; burst_len = 8'd0; d_par = 16'h0;
    d_ser1 = 1'b0; d_ser4 = 4'h0; pat = 16'h0007;
    for (int k = 0; k < 2; k++) begin
      mout[k] = 16'h0; mser[k] = 4'h0; mbusy[k] = 1'b0; mdone[k] = 1'b0; mcnt[k] = 0; dcnt[k] = 0;
    end
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check_all("reset");

    en_op(6, 16'h8001, 1'b0, 4'h0, 1'b1, "load");
    en_op(3, 16'h0000, 1'b0, 4'h0, 1'b1, "rol");
    chk("rol_out", 32'(o_out[0]), 32'h0003);
    chk("rol_ser", 32'(o_ser[0]), 32'h1);

    en_op(6, 16'hA5C3, 1'b0, 4'h0, 1'b1, "load2");
    en_op(5, 16'h0000, 1'b0, 4'h0, 1'b1, "asr");
    chk("asr4_out", 32'(o_out[1]), 32'hFA5C);
    chk("asr4_ser", 32'(o_ser[1]), 32'h3);

    en_op(7, 16'h0000, 1'b0, 4'h0, 1'b1, "clr");
    run_burst(1, 5, 1);
    chk("b5_out", 32'(o_out[0]), 32'h0015);
    tick();
    mdone[0] = 1'b0; mdone[1] = 1'b0;
    chk("b5_done_cnt", 32'(dcnt[0]), 32'd1);
    chk("b5_done_low", 32'(o_done[0]), 32'd0);

    run_burst(1, 0, 0);
    chk("z_out", 32'(o_out[0]), 32'h0015);
    tick();
    mdone[0] = 1'b0; mdone[1] = 1'b0;
    chk("z_done_low", 32'(o_done[0]), 32'd0);

    mode = 3'd6; en = 1'b1; start = 1'b1; burst_len = 8'd3; d_par = 16'h1234;
    tick();
    start = 1'b0; en = 1'b0;
    mout[0] = 16'h1234; mout[1] = 16'h1234;
    check_all("ldstart");

    run_burst(1, 2, 0);
    chk("b2b_done", 32'(o_done[0]), 32'd1);
    run_burst(2, 1, 0);

    en_op(7, 16'h0000, 1'b0, 4'h0, 1'b1, "clr2");
    mode = 3'd1; start = 1'b1; burst_len = 8'd8; d_ser1 = 1'b1; d_ser4 = 4'h1;
    tick();
    start = 1'b0; en = 1'b1; mode = 3'd7;
    tick(); tick();
    chk("rb_out1", 32'(o_out[0]), 32'h0003);
    chk("rb_out4", 32'(o_out[1]), 32'h0011);
    chk("rb_busy", 32'(o_busy[0]), 32'd1);
    rst = 1'b1; en = 1'b0;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mout[k] = 16'h0; mser[k] = 4'h0; mbusy[k] = 1'b0; mdone[k] = 1'b0;
    end
    check_all("rst_mid");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_nodone", 32'(o_done[0] | o_done[1]), 32'd0);
      chk("rst_nobusy", 32'(o_busy[0] | o_busy[1]), 32'd0);
    end

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 4);
      if (r == 0) run_burst($urandom_range(1, 5), $urandom_range(0, 6), 0);
      else en_op($urandom_range(0, 7), 16'($urandom), 1'($urandom), 4'($urandom), r != 1, "rnd");
    end

`ifdef PATTERN_MATCH_EN
    en_op(7, 16'h0000, 1'b0, 4'h0, 1'b1, "clr3");
    run_burst(1, 10, 2);
    chk("pm_out", 32'(o_out[0]), 32'h0007);
    chk("pm_match", 32'(b1.match), 32'd1);
    chk("pm_done_cnt", 32'(dcnt[0]), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
